// File: rtl/ppg_cal_ctrl.sv
// ppg_cal_ctrl -- PPG front-end calibration and LED multiplexing controller.
//
// After find_setting, each LED channel is calibrated in turn. First the
// DC-compensation code is found by MSB-first successive approximation with the
// PGA at gain 0. Then the PGA gain is raised one code per window until the
// signal clips. Once the last channel is calibrated, the block enters
// operation: it round-robins the LEDs, applies each channel's stored settings,
// and captures one ADC sample per slot.
//
// Optional build macro:
//   OPER_AVG_EN - in operation, the captured value is the mean of the last 4
//                 samples of the slot (requires SLOT_LEN >= 4). Without it,
//                 the last-cycle sample is captured.
//
// Ports:
//   CLK          clock (posedge only)
//   rst_n        asynchronous active-low reset
//   find_setting level; starts or restarts calibration every cycle it is high
//   adc          AFE sample
//   led_en       one-hot LED enable
//   led_drive    constant LED current code
//   dc_comp      DC compensation code to the AFE
//   pga_gain     PGA gain code to the AFE
//   busy         calibration running
//   done         calibration complete, operation active
//   cal_fail     per-channel DC tolerance miss
//   ch_value     last captured sample per channel (ch0 in the LSBs)
//   sample_valid one-cycle pulse after a capture
//   sample_ch    channel of that capture
module ppg_cal_ctrl #(
    parameter int NUM_CH        = 2,
    parameter int ADC_W         = 8,
    parameter int DC_W          = 7,
    parameter int PGA_W         = 4,
    parameter int WIN_LEN       = 1000,
    parameter int SETTLE_CYC    = 16,
    parameter int TARGET        = 128,
    parameter int DC_TOL        = 8,
    parameter int CLIP_LO       = 10,
    parameter int CLIP_HI       = 245,
    parameter int SLOT_LEN      = 10,
    parameter int LED_DRIVE_VAL = 10
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      find_setting,
    input  logic [ADC_W-1:0]          adc,
    output logic [NUM_CH-1:0]         led_en,
    output logic [3:0]                led_drive,
    output logic [DC_W-1:0]           dc_comp,
    output logic [PGA_W-1:0]          pga_gain,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH-1:0]         cal_fail,
    output logic [NUM_CH*ADC_W-1:0]   ch_value,
    output logic                      sample_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sample_ch
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = $clog2(WIN_LEN + SETTLE_CYC + 1);
    localparam int SLOT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int BIT_W  = (DC_W > 1) ? $clog2(DC_W) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DC   = 2'd1;
    localparam logic [1:0] ST_PGA  = 2'd2;
    localparam logic [1:0] ST_OP   = 2'd3;

    // Window timing: win_cnt 0..SETTLE-1 settle, SETTLE..EVAL_AT-1 sample,
    // EVAL_AT evaluates and applies the next setting.
    localparam logic [CNT_W-1:0]  SMP_FIRST = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0]  EVAL_AT   = CNT_W'(SETTLE_CYC + WIN_LEN);
    localparam logic [ADC_W-1:0]  TARGET_V  = ADC_W'(TARGET);
    localparam logic [ADC_W-1:0]  DC_TOL_V  = ADC_W'(DC_TOL);
    localparam logic [ADC_W-1:0]  CLIP_LO_V = ADC_W'(CLIP_LO);
    localparam logic [ADC_W-1:0]  CLIP_HI_V = ADC_W'(CLIP_HI);
    localparam logic [PGA_W-1:0]  PGA_MAX   = {PGA_W{1'b1}};
    localparam logic [DC_W-1:0]   DC_MSB    = DC_W'(1'b1) << (DC_W - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(DC_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = {NUM_CH{1'b0}};
        v[ch] = 1'b1;
        return v;
    endfunction

    logic [1:0]              st_r;
    logic [CH_W-1:0]         ch_r;
    logic [CNT_W-1:0]        win_cnt_r;
    logic [ADC_W-1:0]        min_r, max_r;
    logic [BIT_W-1:0]        bit_idx_r;
    logic [SLOT_W-1:0]       slot_cnt_r;
    logic [DC_W-1:0]         dc_store_r  [NUM_CH];
    logic [PGA_W-1:0]        pga_store_r [NUM_CH];
    logic [NUM_CH-1:0]       led_en_r;
    logic [3:0]              led_drive_r;
    logic [DC_W-1:0]         dc_comp_r;
    logic [PGA_W-1:0]        pga_gain_r;
    logic                    busy_r, done_r, sample_valid_r;
    logic [NUM_CH-1:0]       cal_fail_r;
    logic [NUM_CH*ADC_W-1:0] ch_value_r;
    logic [CH_W-1:0]         sample_ch_r;

    logic [ADC_W:0]          sum_s;
    logic [ADC_W-1:0]        mid_s, dev_s, cap_val_s;
    logic                    keep_s, tol_miss_s, clipped_s;
    logic [DC_W-1:0]         dc_code_s;
    logic [PGA_W-1:0]        pga_final_s;
    logic [CH_W-1:0]         op_next_s;

`ifdef OPER_AVG_EN
    logic [ADC_W-1:0]        hist_r [3];
    logic [ADC_W+1:0]        sum4_s;

    // Last three ADC samples for the slot-end average.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist_r[i] <= {ADC_W{1'b0}};
        end else begin
            hist_r[0] <= adc;
            hist_r[1] <= hist_r[0];
            hist_r[2] <= hist_r[1];
        end
    end

    // Mean of the current sample and the three before it, truncated.
    always_comb begin
        sum4_s    = {2'b00, adc} + {2'b00, hist_r[0]} + {2'b00, hist_r[1]} + {2'b00, hist_r[2]};
        cap_val_s = ADC_W'(sum4_s >> 2);
    end
`else
    // Captured value is simply the slot's last sample.
    always_comb begin
        cap_val_s = adc;
    end
`endif

    // Window evaluation: midpoint, SAR bit decision, tolerance and clip tests.
    always_comb begin
        sum_s = {1'b0, max_r} + {1'b0, min_r};
        mid_s = ADC_W'(sum_s >> 1);
        keep_s = (mid_s >= TARGET_V);
        if (keep_s) begin
            dc_code_s = dc_comp_r;
            dev_s     = mid_s - TARGET_V;
        end else begin
            dc_code_s = dc_comp_r & ~(DC_W'(1'b1) << bit_idx_r);
            dev_s     = TARGET_V - mid_s;
        end
        // The tolerance is judged on the last SAR window (trial of the LSB).
        tol_miss_s = (dev_s > DC_TOL_V);
        clipped_s  = (min_r <= CLIP_LO_V) || (max_r >= CLIP_HI_V);
        if (clipped_s) begin
            if (pga_gain_r == {PGA_W{1'b0}}) begin
                pga_final_s = {PGA_W{1'b0}};
            end else begin
                pga_final_s = pga_gain_r - 1'b1;
            end
        end else begin
            pga_final_s = pga_gain_r;
        end
        if (ch_r == LAST_CH) begin
            op_next_s = {CH_W{1'b0}};
        end else begin
            op_next_s = ch_r + 1'b1;
        end
    end

    // Calibration / operation sequencer and all registered outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            st_r           <= ST_IDLE;
            ch_r           <= {CH_W{1'b0}};
            win_cnt_r      <= {CNT_W{1'b0}};
            min_r          <= {ADC_W{1'b0}};
            max_r          <= {ADC_W{1'b0}};
            bit_idx_r      <= {BIT_W{1'b0}};
            slot_cnt_r     <= {SLOT_W{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                dc_store_r[i]  <= {DC_W{1'b0}};
                pga_store_r[i] <= {PGA_W{1'b0}};
            end
            led_en_r       <= {NUM_CH{1'b0}};
            led_drive_r    <= 4'(LED_DRIVE_VAL);
            dc_comp_r      <= {DC_W{1'b0}};
            pga_gain_r     <= {PGA_W{1'b0}};
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            sample_valid_r <= 1'b0;
            cal_fail_r     <= {NUM_CH{1'b0}};
            ch_value_r     <= {(NUM_CH*ADC_W){1'b0}};
            sample_ch_r    <= {CH_W{1'b0}};
        end else if (find_setting) begin
            st_r           <= ST_DC;
            ch_r           <= {CH_W{1'b0}};
            win_cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r      <= BIT_TOP;
            slot_cnt_r     <= {SLOT_W{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                dc_store_r[i]  <= {DC_W{1'b0}};
                pga_store_r[i] <= {PGA_W{1'b0}};
            end
            led_en_r       <= ch_onehot({CH_W{1'b0}});
            dc_comp_r      <= DC_MSB;
            pga_gain_r     <= {PGA_W{1'b0}};
            busy_r         <= 1'b1;
            done_r         <= 1'b0;
            sample_valid_r <= 1'b0;
            cal_fail_r     <= {NUM_CH{1'b0}};
        end else begin
            sample_valid_r <= 1'b0;
            case (st_r)
                ST_IDLE: begin
                    st_r <= ST_IDLE;
                end
                ST_DC, ST_PGA: begin
                    if (win_cnt_r == EVAL_AT) begin
                        win_cnt_r <= {CNT_W{1'b0}};
                        if (st_r == ST_DC) begin
                            if (bit_idx_r == {BIT_W{1'b0}}) begin
                                dc_store_r[ch_r] <= dc_code_s;
                                cal_fail_r[ch_r] <= tol_miss_s;
                                dc_comp_r        <= dc_code_s;
                                pga_gain_r       <= {PGA_W{1'b0}};
                                st_r             <= ST_PGA;
                            end else begin
                                dc_comp_r <= dc_code_s | (DC_W'(1'b1) << (bit_idx_r - 1'b1));
                                bit_idx_r <= bit_idx_r - 1'b1;
                            end
                        end else if (!clipped_s && (pga_gain_r != PGA_MAX)) begin
                            pga_gain_r <= pga_gain_r + 1'b1;
                        end else begin
                            pga_store_r[ch_r] <= pga_final_s;
                            if (ch_r == LAST_CH) begin
                                st_r       <= ST_OP;
                                ch_r       <= {CH_W{1'b0}};
                                slot_cnt_r <= {SLOT_W{1'b0}};
                                busy_r     <= 1'b0;
                                done_r     <= 1'b1;
                                led_en_r   <= ch_onehot({CH_W{1'b0}});
                                dc_comp_r  <= dc_store_r[0];
                                // With a single channel, ch0's gain is the one being stored now.
                                pga_gain_r <= (ch_r == {CH_W{1'b0}}) ? pga_final_s : pga_store_r[0];
                            end else begin
                                st_r       <= ST_DC;
                                ch_r       <= ch_r + 1'b1;
                                bit_idx_r  <= BIT_TOP;
                                led_en_r   <= ch_onehot(ch_r + 1'b1);
                                dc_comp_r  <= DC_MSB;
                                pga_gain_r <= {PGA_W{1'b0}};
                            end
                        end
                    end else begin
                        win_cnt_r <= win_cnt_r + 1'b1;
                        if (win_cnt_r == SMP_FIRST) begin
                            min_r <= adc;
                            max_r <= adc;
                        end else if (win_cnt_r > SMP_FIRST) begin
                            if (adc < min_r) min_r <= adc;
                            if (adc > max_r) max_r <= adc;
                        end
                    end
                end
                ST_OP: begin
                    if (slot_cnt_r == SLOT_LAST) begin
                        ch_value_r[ch_r*ADC_W +: ADC_W] <= cap_val_s;
                        sample_valid_r <= 1'b1;
                        sample_ch_r    <= ch_r;
                        ch_r           <= op_next_s;
                        slot_cnt_r     <= {SLOT_W{1'b0}};
                        led_en_r       <= ch_onehot(op_next_s);
                        dc_comp_r      <= dc_store_r[op_next_s];
                        pga_gain_r     <= pga_store_r[op_next_s];
                    end else begin
                        slot_cnt_r <= slot_cnt_r + 1'b1;
                    end
                end
                default: begin
                    st_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign led_en       = led_en_r;
    assign led_drive    = led_drive_r;
    assign dc_comp      = dc_comp_r;
    assign pga_gain     = pga_gain_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign cal_fail     = cal_fail_r;
    assign ch_value     = ch_value_r;
    assign sample_valid = sample_valid_r;
    assign sample_ch    = sample_ch_r;

endmodule

// File: tb/tb_ppg_cal_ctrl.sv
// Self-checking bench for ppg_cal_ctrl (NUM_CH=2, short windows).
// The ADC model depends on the DUT's LED/DC/PGA outputs: a "ripple" channel
// gives 200-dc with ripple +/-10*(gain+1), and a "flat" channel gives 100-dc.
// DC trial codes and operation captures are checked through scoreboards.
module tb_ppg_cal_ctrl;
    localparam int SLOT_LEN = 10;
    localparam int WIN_LEN  = 16;
    localparam int SETTLE   = 4;
    localparam int WIN_PER  = WIN_LEN + SETTLE + 1;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        find_setting = 1'b0;
    logic [7:0]  adc = 8'd0;
    logic [1:0]  led_en;
    logic [3:0]  led_drive;
    logic [6:0]  dc_comp;
    logic [3:0]  pga_gain;
    logic        busy, done, sample_valid;
    logic [1:0]  cal_fail;
    logic [15:0] ch_value;
    logic [0:0]  sample_ch;

    ppg_cal_ctrl #(.NUM_CH(2), .WIN_LEN(WIN_LEN), .SETTLE_CYC(SETTLE), .SLOT_LEN(SLOT_LEN)) dut (
        .CLK(CLK), .rst_n(rst_n), .find_setting(find_setting), .adc(adc),
        .led_en(led_en), .led_drive(led_drive), .dc_comp(dc_comp), .pga_gain(pga_gain),
        .busy(busy), .done(done), .cal_fail(cal_fail), .ch_value(ch_value),
        .sample_valid(sample_valid), .sample_ch(sample_ch)
    );

    always #5 CLK = ~CLK;

    typedef struct { int ch; int val; int cyc; } cap_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   mode = 0;
    bit   tog = 1'b0;
    bit   fs_req = 1'b0;
    int   cyc = 0;
    int   hist [4];
    int   dc_q [$];
    int   dc_idx = 0;
    int   last_chg = 0;
    int   prev_dc = 0;
    cap_t cap_q [$];
    bit   in_op = 1'b0;
    int   op_cyc = 0;
    int   exp_dc [2];
    int   exp_pga [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] adc_model(input bit ripple, input int dc, input int gain, input bit t);
        int mean, amp, v;
        mean = ripple ? 200 - dc : 100 - dc;
        amp  = ripple ? 10 * (gain + 1) : 0;
        v    = t ? mean + amp : mean - amp;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic monitor();
        int e, ch, pos, expv;
        cap_t c;
        // DC trial scoreboard: every code change while busy must match the next expected trial.
        if (busy && int'(dc_comp) != prev_dc) begin
            if (dc_q.size() == 0) begin
                chk("dc_extra", dc_q.size(), 1);
            end else begin
                e = dc_q.pop_front();
                chk("dc_trial", dc_comp, e);
                if (dc_idx % 8 != 0) chk("win_period", cyc - last_chg, WIN_PER);
                dc_idx++;
                last_chg = cyc;
            end
        end
        prev_dc = int'(dc_comp);

        if (done) begin
            if (!in_op) begin in_op = 1'b1; op_cyc = 0; end
            else op_cyc++;
        end else begin
            in_op = 1'b0;
            cap_q.delete();
        end

        if (in_op && cap_q.size() > 0 && op_cyc == cap_q[0].cyc + 1) begin
            c = cap_q.pop_front();
            chk("sv_pulse", sample_valid, 1);
            chk("sample_ch", sample_ch, c.ch);
            chk("ch_value", ch_value[c.ch*8 +: 8], c.val);
        end else if (sample_valid) begin
            chk("sv_stray", sample_valid, 0);
        end

        if (in_op) begin
            ch  = (op_cyc / SLOT_LEN) % 2;
            pos = op_cyc % SLOT_LEN;
            if (pos == 0) begin
                chk("op_led_en", led_en, 1 << ch);
                chk("op_dc", dc_comp, exp_dc[ch]);
                chk("op_pga", pga_gain, exp_pga[ch]);
            end
            if (pos == SLOT_LEN - 1 && !find_setting) begin
`ifdef OPER_AVG_EN
                expv = (hist[0] + hist[1] + hist[2] + hist[3]) >> 2;
`else
                expv = hist[0];
`endif
                cap_q.push_back('{ch: ch, val: expv, cyc: op_cyc});
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        find_setting = fs_req;
        tog = ~tog;
        if (done) adc = 8'($urandom_range(0, 255));
        else if (led_en[0]) adc = adc_model(mode == 0, int'(dc_comp), int'(pga_gain), tog);
        else if (led_en[1]) adc = adc_model(mode == 1, int'(dc_comp), int'(pga_gain), tog);
        else adc = 8'd0;
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(adc);
        @(negedge CLK);
        cyc++;
        monitor();
    endtask

    task automatic push_seq(input bit ripple);
        if (ripple) begin
            dc_q.push_back(64); dc_q.push_back(96); dc_q.push_back(80); dc_q.push_back(72);
            dc_q.push_back(76); dc_q.push_back(74); dc_q.push_back(73); dc_q.push_back(72);
        end else begin
            dc_q.push_back(64); dc_q.push_back(32); dc_q.push_back(16); dc_q.push_back(8);
            dc_q.push_back(4);  dc_q.push_back(2);  dc_q.push_back(1);  dc_q.push_back(0);
        end
    endtask

    task automatic start_cal(input int m);
        dc_q.delete();
        push_seq(m == 0);
        push_seq(m == 1);
        dc_idx = 0;
        fs_req = 1'b1;
        tick();
        fs_req = 1'b0;
        mode = m;
        tick();
        chk("rs_done", done, 0);
        chk("rs_busy", busy, 1);
        chk("rs_dc_msb", dc_comp, 64);
        chk("rs_pga", pga_gain, 0);
        chk("rs_led_en", led_en, 1);
        chk("rs_cal_fail", cal_fail, 0);
        exp_dc[0]  = (m == 0) ? 72 : 0;
        exp_dc[1]  = (m == 0) ? 0 : 72;
        exp_pga[0] = (m == 0) ? 10 : 15;
        exp_pga[1] = (m == 0) ? 15 : 10;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        chk("done_rise", done, 1);
        chk("busy_fall", busy, 0);
        chk("dc_q_drained", dc_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = 0;
        #12;
        chk("rst_led_en", led_en, 0);
        chk("rst_led_drive", led_drive, 10);
        chk("rst_dc", dc_comp, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ch_value", ch_value, 0);
        #10 rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_busy", busy, 0);
        chk("idle_led_en", led_en, 0);

        // Round 1: ch0 ripple model (dc 72, gain 10), ch1 flat model (dc 0, fail, gain 15).
        start_cal(0);
        wait_done();
        chk("cal_fail_r1", cal_fail, 2);
        repeat (60) tick();

        // Round 2: restart from operation with models swapped.
        start_cal(1);
        wait_done();
        chk("cal_fail_r2", cal_fail, 1);
        repeat (60) tick();

        // Asynchronous reset in the middle of operation.
        @(posedge CLK);
        #3 rst_n = 1'b0;
        #1;
        chk("mr_led_en", led_en, 0);
        chk("mr_led_drive", led_drive, 10);
        chk("mr_done", done, 0);
        chk("mr_dc", dc_comp, 0);
        chk("mr_pga", pga_gain, 0);
        chk("mr_cal_fail", cal_fail, 0);
        chk("mr_sv", sample_valid, 0);
        chk("mr_ch_value", ch_value, 0);
        @(negedge CLK);
        #2 rst_n = 1'b1;
        repeat (30) tick();
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_led_en", led_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
